// File: rtl/dram_pkg.sv
// Shared definitions for the dispatch RAM diagnostic loader.
package dram_pkg;

    localparam int unsigned DRAM_WIDTH     = 15;
    localparam int unsigned DRAM_ADDR_BITS = 9;

    // diag_func codes; the "load" meaning applies to diag_load, the read map reuses the codes
    typedef enum logic [2:0] {
        FN_ADDR_HI   = 3'b000,
        FN_ADDR_LO   = 3'b001,
        FN_STAGE_AB  = 3'b010,
        FN_STAGE_PJ  = 3'b011,
        FN_STAGE_J7  = 3'b100,
        FN_COMMIT_WR = 3'b101,
        FN_COMMIT_RD = 3'b110,
        FN_CLEAR     = 3'b111
    } diag_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RDW  = 2'd3
    } state_e;

endpackage

// File: rtl/dram_parity.sv
// Odd-parity generator: p makes {data, p} contain an odd number of ones.
module dram_parity (
    input  logic [0:13] data,
    output logic        p
);

    // Drive p high exactly when the other fourteen bits have even parity
    always_comb begin
        p = ~(^data);
    end

endmodule

// File: rtl/dram_loader.sv
// Diagnostic EBUS loader for the dispatch RAM: stages an address and a
// 15-bit word through 6-bit EBUS transfers, then commits a write or read.
module dram_loader #(
    parameter int unsigned DRAM_WIDTH     = dram_pkg::DRAM_WIDTH,
    parameter int unsigned DRAM_ADDR_BITS = dram_pkg::DRAM_ADDR_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      diag_load,
    input  logic                      diag_read,
    input  logic [2:0]                diag_func,
    input  logic [0:5]                ebus_in,
    output logic [0:5]                ebus_out,
    output logic                      ebus_driving,
    output logic [0:DRAM_ADDR_BITS-1] ram_addr,
    output logic [0:DRAM_WIDTH-1]     ram_wdata,
    output logic                      ram_we,
    input  logic [0:DRAM_WIDTH-1]     ram_rdata,
    output logic                      busy
);

    import dram_pkg::*;

    state_e                    state;
    state_e                    state_nxt;
    diag_fn_e                  fn;
    logic [0:DRAM_ADDR_BITS-1] addr;
    logic [0:DRAM_WIDTH-1]     stage;
    logic                      overrun;
    logic                      wrap;
    logic                      inc_pend;
    logic                      gen_p;
    logic                      parity_ok;

    assign fn           = diag_fn_e'(diag_func);
    assign ram_addr     = addr;
    assign ram_wdata    = stage;
    assign ebus_driving = diag_read;
    assign parity_ok    = ^stage;

    // P sits at stage[6]; parity is generated over the remaining fourteen bits
    dram_parity u_parity (
        .data ({stage[0:5], stage[7:14]}),
        .p    (gen_p)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; ram_we and busy come straight from state so reset drops them at once
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (diag_load && fn == FN_COMMIT_WR) begin
                    state_nxt = ST_WR;
                end else if (diag_load && fn == FN_COMMIT_RD) begin
                    state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                ram_we    = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RD: begin
                busy      = 1'b1;
                state_nxt = ST_RDW;
            end
            ST_RDW: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address, staging word and sticky flags; loads are honoured only in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            stage    <= '0;
            overrun  <= 1'b0;
            wrap     <= 1'b0;
            inc_pend <= 1'b0;
        end else begin
            if (diag_load && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (diag_load) begin
                        case (fn)
                            FN_ADDR_HI:  addr[0:2]    <= ebus_in[3:5];
                            FN_ADDR_LO:  addr[3:8]    <= ebus_in[0:5];
                            FN_STAGE_AB: stage[0:5]   <= ebus_in[0:5];
                            FN_STAGE_PJ: stage[6:10]  <= ebus_in[1:5];
                            FN_STAGE_J7: stage[11:14] <= ebus_in[2:5];
                            FN_COMMIT_WR: begin
                                // Generated P lands in stage so WR simply drives stage
                                inc_pend <= ebus_in[5];
                                if (ebus_in[0]) begin
                                    stage[6] <= gen_p;
                                end
                            end
                            FN_COMMIT_RD: ;
                            FN_CLEAR: begin
                                stage   <= '0;
                                overrun <= 1'b0;
                                wrap    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WR: begin
                    inc_pend <= 1'b0;
                    if (inc_pend) begin
                        addr <= addr + 1'b1;
                        if (addr == '1) begin
                            wrap <= 1'b1;
                        end
                    end
                end
                ST_RDW: stage <= ram_rdata;
                default: ;
            endcase
        end
    end

    // EBUS read map, combinational on pre-edge state
    always_comb begin
        ebus_out = '0;
        if (diag_read) begin
            case (fn)
                FN_ADDR_HI:  ebus_out = {busy, overrun, wrap, addr[0:2]};
                FN_ADDR_LO:  ebus_out = addr[3:8];
                FN_STAGE_AB: ebus_out = stage[0:5];
                FN_STAGE_PJ: ebus_out = {1'b0, stage[6:10]};
                FN_STAGE_J7: ebus_out = {parity_ok, 1'b0, stage[11:14]};
                default:     ebus_out = '0;
            endcase
        end
    end

endmodule
